restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter N, default 16, operand/result width; even, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begins an operand-load sequence; sampled only in IDLE or DONE.
REQ-005 SHALL have port inBus  input  N/2  operand half-word, one per load cycle.
REQ-006 SHALL have port outSel  input  1  0 = quotient, 1 = remainder on outBus.
REQ-007 SHALL have port outBus  output  N  selected result; combinational from the result registers.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-009 SHALL have port done  output  1  high in DONE; results valid.
REQ-010 SHALL have port divByZero  output  1  registered; high in DONE when the divisor was 0.

Function
REQ-011 SHALL perform unsigned division of an N-bit dividend by an N-bit divisor using the restoring algorithm, 1 quotient bit per cycle.
REQ-012 SHALL implement FSM states IDLE, LD1, LD2, LD3, CHECK, DIV, DONE.
REQ-013 SHALL, on edge E0 with start=1 in IDLE or DONE: capture inBus as dividend low half, clear done and divByZero, go to LD1.
REQ-014 SHALL capture dividend high half at E1 (LD1), divisor low half at E2 (LD2), divisor high half at E3 (LD3); LD3 goes to CHECK.
REQ-015 SHALL, in CHECK at E4: if divisor = 0, set divByZero, quotient = all ones, remainder = dividend, go to DONE; otherwise clear the N+1-bit partial remainder R, load quotient register Q with the dividend, clear the iteration counter, go to DIV.
REQ-016 SHALL, per DIV cycle: shift {R,Q} left by 1; compute trial = R - divisor (N+1 bits); if trial >= 0, R = trial and Q[0] = 1, else R unchanged and Q[0] = 0.
REQ-017 SHALL execute exactly N DIV iterations (E5..E(N+4)); the last iteration goes to DONE, so done is high after E(N+4) (E20 for N=16).
REQ-018 SHALL present remainder as R[N-1:0] (R[N] is always 0 after a restoring step).
REQ-019 SHALL hold DONE, results and divByZero until the next accepted start or reset.
REQ-020 SHALL ignore start while busy=1; no state, operand or result change.
REQ-021 SHALL, when start=1 in DONE, treat it as a new E0 (REQ-013); done falls the following cycle.
REQ-022 SHALL leave outBus value unspecified while busy=1; consumers use it only when done=1.
REQ-023 SHALL keep outSel purely combinational; changing it never alters internal state.

Reset
REQ-024 SHALL, while rst=1, immediately force state IDLE and clear operand, R, Q and counter registers, divByZero, done and busy to 0; outBus = 0 for either outSel.
REQ-025 SHALL abort any operation in progress (load, CHECK or DIV) on rst; the first start after rst release begins a fresh sequence.

Verification
REQ-026 SHALL verify: start with inBus 0x64,0x00,0x07,0x00 at E0..E3 -> after E20 done=1, busy=0, divByZero=0, outSel=0 gives 0x000E, outSel=1 gives 0x0002.
REQ-027 SHALL verify: 0xFFFF / 0x0001 -> quotient 0xFFFF, remainder 0x0000; 0x0005 / 0x0009 -> quotient 0x0000, remainder 0x0005.
REQ-028 SHALL verify: 0x1234 / 0x0000 -> after E4 done=1, divByZero=1, quotient 0xFFFF, remainder 0x1234.
REQ-029 SHALL verify: start pulses during LD2 and during DIV are ignored -> result of the original operation unchanged, done still after E20.
REQ-030 SHALL verify: rst asserted asynchronously mid-DIV (after E10) -> busy, done, divByZero, outBus 0 without waiting for a clock edge; a subsequent 100/7 completes correctly.
REQ-031 SHALL verify back-to-back: start in DONE with 0xFFFE / 0x0010 -> done low the next cycle, then quotient 0x0FFF, remainder 0x000E after the new E20.

Source files
------------

// File: rtl/restoring_divider.sv
// restoring_divider: N-bit unsigned restoring divider, operands loaded as four half-words,
// one quotient bit per cycle.
module restoring_divider #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N/2-1:0] inBus,
    input  logic           outSel,
    output logic [N-1:0]   outBus,
    output logic           busy,
    output logic           done,
    output logic           divByZero
);
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {IDLE, LD1, LD2, LD3, CHECK, DIV, DONE} state_t;

    state_t        r_state, w_next;
    logic [N-1:0]  r_dvd, r_dvs, r_quo, r_rem, w_diff;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic [N:0]    w_shift;
    logic          w_ge, w_last, w_zero;

    // The partial remainder never exceeds N bits once a step settles, so only the shifted
    // value needs the extra bit for the trial comparison.
    assign w_shift = {r_rem, r_quo[N-1]};
    assign w_ge    = w_shift >= {1'b0, r_dvs};
    assign w_diff  = w_shift[N-1:0] - r_dvs;
    assign w_last  = r_cnt == CW'(N - 1);
    assign w_zero  = r_dvs == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = start ? LD1 : r_state;
            LD1:        w_next = LD2;
            LD2:        w_next = LD3;
            LD3:        w_next = CHECK;
            CHECK:      w_next = w_zero ? DONE : DIV;
            DIV:        w_next = w_last ? DONE : DIV;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_dvd[H-1:0] <= inBus;
                    r_dbz        <= 1'b0;
                end
                LD1: r_dvd[N-1:H] <= inBus;
                LD2: r_dvs[H-1:0] <= inBus;
                LD3: r_dvs[N-1:H] <= inBus;
                CHECK: if (w_zero) begin
                    r_dbz <= 1'b1;
                    r_quo <= '1;
                    r_rem <= r_dvd;
                end else begin
                    r_rem <= '0;
                    r_quo <= r_dvd;
                    r_cnt <= '0;
                end
                DIV: begin
                    r_rem <= w_ge ? w_diff : w_shift[N-1:0];
                    r_quo <= {r_quo[N-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done      = r_state == DONE;
    assign busy      = !(r_state == IDLE || r_state == DONE);
    assign divByZero = r_dbz;
    assign outBus    = outSel ? r_rem : r_quo;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: scoreboard bench for the 16-bit restoring divider with directed
// and random operands checked against plain integer division.
module tb_restoring_divider;
    localparam int N = 16;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N/2-1:0] inBus = '0;
    logic           outSel = 1'b0;
    logic [N-1:0]   outBus;
    logic           busy, done, divByZero;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    restoring_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .inBus(inBus), .outSel(outSel),
        .outBus(outBus), .busy(busy), .done(done), .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.z = (b == 0);
        e.q = e.z ? {N{1'b1}} : a / b;
        e.r = e.z ? a : a % b;
        return e;
    endfunction

    task automatic load(input logic [N-1:0] a, input logic [N-1:0] b, input bit pulse_ld2);
        @(negedge clk);
        start = 1'b1;
        inBus = a[7:0];
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_E0", busy, 1);
        chk("done_after_E0", done, 0);
        start = 1'b0;
        inBus = a[15:8];
        @(posedge clk);
        @(negedge clk);
        start = pulse_ld2;
        inBus = b[7:0];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        inBus = b[15:8];
        @(posedge clk);
    endtask

    // lat: rising edges after E3 until done must be high
    task automatic wait_done(input int lat, input bit pulse_div);
        @(negedge clk);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = pulse_div && i == 5;
            if (start) inBus = 8'($urandom);
        end
        start = 1'b0;
        chk("busy_before_done", busy, 1);
        chk("done_early", done, 0);
        @(posedge clk);
        @(negedge clk);
        chk("done_on_time", done, 1);
        chk("busy_in_done", busy, 0);
    endtask

    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 required no pending operation");
                end else begin
                    e = sb.pop_front();
                    chk("divByZero", divByZero, e.z);
                    outSel = 1'b0;
                    #1 chk("quotient", outBus, e.q);
                    outSel = 1'b1;
                    #1 chk("remainder", outBus, e.r);
                    outSel = 1'b0;
                end
            end
            prev = done;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a, b;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", divByZero, 0);
        chk("rst_q", outBus, 0);
        outSel = 1'b1;
        #1 chk("rst_r", outBus, 0);
        outSel = 1'b0;
        rst = 1'b0;

        load(16'd100, 16'd7, 0);       wait_done(N + 1, 0);
        load(16'hFFFF, 16'h0001, 0);   wait_done(N + 1, 0);
        load(16'h0005, 16'h0009, 0);   wait_done(N + 1, 0);
        load(16'h1234, 16'h0000, 0);   wait_done(1, 0);
        load(16'd100, 16'd7, 1);       wait_done(N + 1, 1);

        load(16'd100, 16'd7, 0);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_dbz", divByZero, 0);
        outSel = 1'b0;
        #1 chk("arst_q", outBus, 0);
        outSel = 1'b1;
        #1 chk("arst_r", outBus, 0);
        outSel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load(16'd100, 16'd7, 0);       wait_done(N + 1, 0);
        load(16'hFFFE, 16'h0010, 0);   wait_done(N + 1, 0);

        for (int k = 0; k < 24; k++) begin
            a = N'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            else if ($urandom_range(0, 1) == 1) b = N'($urandom_range(1, 255));
            else b = N'($urandom);
            load(a, b, $urandom_range(0, 3) == 0);
            wait_done(b == 0 ? 1 : N + 1, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
